// File: rtl/instr_encoder_loader.sv
// Packs a mnemonic index plus operand fields into a MIPS32 word and streams it into IM via a FIFO.
// Latency: word accepted on edge N is writable in cycle N+1; in_ready drops when full, im_busy stalls writes.

module instr_encoder_loader_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             full,
  output logic             empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [AW:0]      cnt_q;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset: the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_dat;
  end

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == (AW+1)'(DEPTH));
  assign head_dat = empty ? '0 : mem_q[rd_ptr_q];
endmodule

module instr_encoder_loader #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
  parameter int          IM_WORDS  = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        restart,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_mnem,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_shamt,
  input  logic [15:0] in_imm,
  input  logic [25:0] in_target,
  input  logic        im_busy,
  output logic        im_we,
  output logic [31:0] im_addr,
  output logic [31:0] im_wdata,
  output logic [15:0] words_written,
  output logic        err_unsupported,
  output logic        wrapped
);
  localparam logic [31:0] TOP_ADDR = BASE_ADDR + 32'(4 * (IM_WORDS - 1));

  typedef enum logic [1:0] {FMT_I, FMT_J, FMT_R, FMT_RI} fmt_e;

  fmt_e        fmt;
  logic [5:0]  op, funct;
  logic [4:0]  ri_rt;
  logic        supported;
  logic [31:0] enc_word;

  logic        fifo_full, fifo_empty, push, xfer;
  logic [31:0] ptr_q, ptr_d;
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d, wrap_q, wrap_d;

  always_comb begin
    fmt       = FMT_I;
    op        = 6'h00;
    funct     = 6'h00;
    ri_rt     = 5'd0;
    supported = 1'b1;
    if (in_mnem >= 6'd22 && in_mnem <= 6'd39) fmt = FMT_R;
    case (in_mnem)
      6'd0:  op = 6'h0D;
      6'd1:  op = 6'h23;
      6'd2:  op = 6'h2B;
      6'd3:  op = 6'h04;
      6'd4:  op = 6'h0F;
      6'd5:  begin op = 6'h02; fmt = FMT_J; end
      6'd6:  begin op = 6'h03; fmt = FMT_J; end
      6'd7:  op = 6'h08;
      6'd8:  op = 6'h09;
      6'd9:  op = 6'h0A;
      6'd10: op = 6'h07;
      6'd11: op = 6'h06;
      6'd12: op = 6'h05;
      6'd13: op = 6'h21;
      6'd14: op = 6'h25;
      6'd15: op = 6'h20;
      6'd16: op = 6'h24;
      6'd17: op = 6'h29;
      6'd18: op = 6'h28;
      6'd19: op = 6'h0C;
      6'd20: op = 6'h0B;
      6'd21: op = 6'h0E;
      6'd22: funct = 6'h21;
      6'd23: funct = 6'h23;
      6'd24: funct = 6'h08;
      6'd25: funct = 6'h00;
      6'd26: funct = 6'h20;
      6'd27: funct = 6'h09;
      6'd28: funct = 6'h24;
      6'd29: funct = 6'h27;
      6'd30: funct = 6'h04;
      6'd31: funct = 6'h2A;
      6'd32: funct = 6'h2B;
      6'd33: funct = 6'h07;
      6'd34: funct = 6'h06;
      6'd35: funct = 6'h26;
      6'd36: funct = 6'h22;
      6'd37: funct = 6'h25;
      6'd38: funct = 6'h02;
      6'd39: funct = 6'h03;
      // REGIMM branches: the rt slot selects bgez (1) vs bltz (0).
      6'd40: begin fmt = FMT_RI; ri_rt = 5'd1; end
      6'd41: begin fmt = FMT_RI; ri_rt = 5'd0; end
      default: supported = 1'b0;
    endcase
  end

  always_comb begin
    case (fmt)
      FMT_J:   enc_word = {op, in_target};
      FMT_R:   enc_word = {6'h00, in_rs, in_rt, in_rd, in_shamt, funct};
      FMT_RI:  enc_word = {6'h01, in_rs, ri_rt, in_imm};
      default: enc_word = {op, in_rs, in_rt, in_imm};
    endcase
  end

  assign in_ready = !reset && !restart && !fifo_full;
  assign xfer     = in_valid && in_ready;
  assign push     = xfer && supported;
  assign im_we    = !reset && !restart && !fifo_empty && !im_busy;

  instr_encoder_loader_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .flush    (restart),
    .push     (push),
    .push_dat (enc_word),
    .pop      (im_we),
    .head_dat (im_wdata),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_comb begin
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    err_d  = err_q | (xfer && !supported);
    wrap_d = wrap_q;
    if (im_we) begin
      ptr_d  = (ptr_q == TOP_ADDR) ? BASE_ADDR : ptr_q + 32'd4;
      wrap_d = wrap_q | (ptr_q == TOP_ADDR);
      if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || restart) begin
      ptr_q  <= BASE_ADDR;
      cnt_q  <= 16'd0;
      err_q  <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
      wrap_q <= wrap_d;
    end
  end

  assign im_addr         = ptr_q;
  assign words_written   = cnt_q;
  assign err_unsupported = err_q;
  assign wrapped         = wrap_q;
endmodule

// File: tb/tb_instr_encoder_loader.sv
// Randomized scoreboard bench for instr_encoder_loader with a table-driven encoding model.
module tb_instr_encoder_loader;
  localparam int          DEPTH    = 4;
  localparam int          IM_WORDS = 4;
  localparam logic [31:0] BASE     = 32'h0000_3000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, restart, in_valid, in_ready, im_busy, im_we;
  logic [5:0]  in_mnem;
  logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  logic [31:0] im_addr, im_wdata;
  logic [15:0] words_written;
  logic        err_unsupported, wrapped;

  instr_encoder_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .IM_WORDS(IM_WORDS)) dut (
    .clk(clk), .reset(reset), .restart(restart),
    .in_valid(in_valid), .in_ready(in_ready), .in_mnem(in_mnem),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_imm(in_imm), .in_target(in_target),
    .im_busy(im_busy), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .words_written(words_written), .err_unsupported(err_unsupported), .wrapped(wrapped)
  );

  int          total = 0, bad = 0;
  int          n_wr = 0, accepted = 0;
  bit          err_exp = 0, stop_busy = 0;
  logic [31:0] exp_q [$];

  logic [5:0] iop_tab [0:21] = '{6'h0D, 6'h23, 6'h2B, 6'h04, 6'h0F, 6'h02, 6'h03, 6'h08,
                                 6'h09, 6'h0A, 6'h07, 6'h06, 6'h05, 6'h21, 6'h25, 6'h20,
                                 6'h24, 6'h29, 6'h28, 6'h0C, 6'h0B, 6'h0E};
  logic [5:0] fn_tab [0:17]  = '{6'h21, 6'h23, 6'h08, 6'h00, 6'h20, 6'h09, 6'h24, 6'h27,
                                 6'h04, 6'h2A, 6'h2B, 6'h07, 6'h06, 6'h26, 6'h22, 6'h25,
                                 6'h02, 6'h03};

  function automatic logic [31:0] ref_enc(input int m, input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [15:0] imm, input logic [25:0] tgt);
    if (m < 22) begin
      if (m == 5 || m == 6) return {iop_tab[m], tgt};
      return {iop_tab[m], rs, rt, imm};
    end
    if (m < 40) return {6'h00, rs, rt, rd, sh, fn_tab[m-22]};
    return {6'h01, rs, (m == 40) ? 5'd1 : 5'd0, imm};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every IM write must match the oldest outstanding encoded word.
  always @(negedge clk) begin
    if (im_we) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL spurious_write actual_addr=%h actual_data=%h required=no_write @%0t",
                 im_addr, im_wdata, $time);
      end else begin
        chk("wdata", im_wdata, exp_q.pop_front());
        chk("addr", im_addr, BASE + 32'(4 * (n_wr % IM_WORDS)));
        chk("words_written", {16'd0, words_written}, (n_wr > 65535) ? 32'd65535 : 32'(n_wr));
        chk("wrapped", {31'd0, wrapped}, {31'd0, (n_wr >= IM_WORDS)});
        n_wr++;
      end
    end
  end

  task automatic send(input logic [5:0] m, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                      input logic [25:0] tgt, input logic [31:0] exp_word);
    int guard;
    guard = 0;
    in_mnem = m; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh;
    in_imm = imm; in_target = tgt; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      guard++;
      @(negedge clk);
    end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL handshake_timeout mnem=%0d actual_ready=%b required=1", m, in_ready);
    end else begin
      if (m >= 6'd42) err_exp = 1'b1;
      else exp_q.push_back(exp_word);
      accepted++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic rnd_send(input int lo, input int hi);
    logic [5:0]  m;
    logic [4:0]  rs, rt, rd, sh;
    logic [15:0] imm;
    logic [25:0] tgt;
    m = 6'($urandom_range(lo, hi));
    rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom); sh = 5'($urandom);
    imm = 16'($urandom); tgt = 26'($urandom);
    send(m, rs, rt, rd, sh, imm, tgt, ref_enc(int'(m), rs, rt, rd, sh, imm, tgt));
  endtask

  task automatic do_restart();
    restart = 1'b1;
    exp_q.delete(); n_wr = 0; err_exp = 1'b0;
    @(negedge clk);
    chk("restart_im_we", {31'd0, im_we}, 32'd0);
    chk("restart_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    restart = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      guard++;
      @(negedge clk);
    end
    chk("drain_outstanding", 32'(exp_q.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; restart = 1'b0; in_valid = 1'b0; im_busy = 1'b0;
    in_mnem = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_shamt = '0; in_imm = '0; in_target = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_im_we", {31'd0, im_we}, 32'd0);
    chk("rst_im_addr", im_addr, BASE);
    chk("rst_im_wdata", im_wdata, 32'd0);
    chk("rst_words", {16'd0, words_written}, 32'd0);
    chk("rst_err", {31'd0, err_unsupported}, 32'd0);
    chk("rst_wrapped", {31'd0, wrapped}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // ori with one-cycle latency
    send(6'd0, 5'd1, 5'd2, 5'd0, 5'd0, 16'h1234, 26'd0, 32'h3422_1234);
    @(negedge clk);
    chk("ori_latency_we", {31'd0, im_we}, 32'd1);
    @(posedge clk); #1;
    drain();
    chk("ori_words", {16'd0, words_written}, 32'd1);
    do_restart();

    // back-to-back addu then jal
    send(6'd22, 5'd3, 5'd4, 5'd5, 5'd0, 16'd0, 26'd0, 32'h0064_2821);
    send(6'd6, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'h0000C00, 32'h0C00_0C00);
    @(negedge clk);
    chk("b2b_second_we", {31'd0, im_we}, 32'd1);
    chk("b2b_second_addr", im_addr, BASE + 32'd4);
    @(posedge clk); #1;
    drain();
    do_restart();

    // backpressure: 4 fill the FIFO, the 5th waits; 5th write wraps to BASE
    im_busy = 1'b1;
    accepted = 0;
    fork
      begin
        for (int i = 0; i < 5; i++) rnd_send(0, 41);
      end
      begin
        repeat (8) @(negedge clk);
        chk("bp_accepted", 32'(accepted), 32'd4);
        chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        chk("bp_im_we", {31'd0, im_we}, 32'd0);
        @(posedge clk); #1;
        im_busy = 1'b0;
      end
    join
    drain();
    chk("bp_words", {16'd0, words_written}, 32'd5);
    chk("bp_wrapped", {31'd0, wrapped}, 32'd1);
    chk("bp_addr_after_wrap", im_addr, BASE + 32'd4);
    do_restart();

    // REGIMM branches
    send(6'd40, 5'd7, 5'd0, 5'd0, 5'd0, 16'hFFFE, 26'd0, 32'h04E1_FFFE);
    send(6'd41, 5'd7, 5'd0, 5'd0, 5'd0, 16'hFFFE, 26'd0, 32'h04E0_FFFE);
    drain();

    // unsupported mnemonic: accepted, nothing written, sticky error
    send(6'd50, 5'd1, 5'd1, 5'd1, 5'd1, 16'h1, 26'h1, 32'd0);
    @(negedge clk);
    chk("unsup_err", {31'd0, err_unsupported}, 32'd1);
    chk("unsup_im_we", {31'd0, im_we}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("unsup_err_held", {31'd0, err_unsupported}, 32'd1);
    chk("unsup_words", {16'd0, words_written}, 32'd2);
    @(posedge clk); #1;
    do_restart();
    @(negedge clk);
    chk("restart_err", {31'd0, err_unsupported}, 32'd0);
    chk("restart_addr", im_addr, BASE);
    chk("restart_words", {16'd0, words_written}, 32'd0);
    @(posedge clk); #1;

    // reset with words queued: they must never be written
    im_busy = 1'b1;
    rnd_send(0, 41);
    rnd_send(0, 41);
    reset = 1'b1;
    exp_q.delete(); n_wr = 0; err_exp = 1'b0;
    @(negedge clk);
    chk("midrst_im_we", {31'd0, im_we}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    im_busy = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (6) @(negedge clk);
    chk("midrst_words", {16'd0, words_written}, 32'd0);
    chk("midrst_addr", im_addr, BASE);
    @(posedge clk); #1;

    // randomized traffic with random write-port stalls
    stop_busy = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) rnd_send(0, 63);
        stop_busy = 1'b1;
      end
      begin
        while (!stop_busy) begin
          @(posedge clk); #1;
          im_busy = ($urandom_range(0, 3) == 0);
        end
      end
    join
    im_busy = 1'b0;
    drain();
    chk("rand_err", {31'd0, err_unsupported}, {31'd0, err_exp});
    chk("rand_words", {16'd0, words_written}, 32'(n_wr));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
